// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button debounce blocks.
package btn_pkg;

  // Default timing for a 50 MHz system clock
  localparam int DEB_10MS_50MHZ = 500000;
  localparam int LONG_1S_50MHZ  = 50000000;

  // Number of bits needed to hold values 0..value-1 (never less than 1)
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: pin synchroniser, debounce, press/release/long pulses
// and a clearable wrapping press counter.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_10MS_50MHZ,
  parameter int LONG_CYCLES     = LONG_1S_50MHZ,
  parameter int CNT_W           = 4,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             cnt_clr,
  output logic             btn_level,
  output logic             btn_press,
  output logic             btn_release,
  output logic             btn_long,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DW = clog2(DEBOUNCE_CYCLES);
  localparam int HW = clog2(LONG_CYCLES + 1);

  // Pin level seen while the button is not pressed
  localparam logic IDLE_PIN = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          raw_n;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;

  // Two-flop synchroniser, reset to the released pin level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Normalise polarity so that 1 always means pressed
  assign raw_n = sync2 ^ IDLE_PIN;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (raw_n == btn_level) begin
        dcnt <= '0;
      end else if (dcnt == DEB_LAST) begin
        dcnt        <= '0;
        btn_level   <= raw_n;
        btn_press   <= raw_n;
        btn_release <= ~raw_n;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // Hold timer: saturates so a long hold fires btn_long exactly once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt     <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (!btn_level) begin
        hcnt <= '0;
      end else if (hcnt != HOLD_MAX) begin
        hcnt <= hcnt + 1'b1;
        if (hcnt == HOLD_LAST) begin
          btn_long <= 1'b1;
        end
      end
    end
  end

  // Press counter: a clear coinciding with a press still keeps that press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_cnt <= '0;
    end else if (cnt_clr) begin
      press_cnt <= CNT_W'(btn_press);
    end else if (btn_press) begin
      press_cnt <= press_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_bank_debounce.sv
// Bank of independent debounced button channels plus a shared any-press flag.
module btn_bank_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEB_10MS_50MHZ,
  parameter int LONG_CYCLES     = LONG_1S_50MHZ,
  parameter int CNT_W           = 4,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_BTN-1:0]       btn_in,
  input  logic [N_BTN-1:0]       cnt_clr,
  output logic [N_BTN-1:0]       btn_level,
  output logic [N_BTN-1:0]       btn_press,
  output logic [N_BTN-1:0]       btn_release,
  output logic [N_BTN-1:0]       btn_long,
  output logic [N_BTN*CNT_W-1:0] press_cnt,
  output logic                   any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .CNT_W           (CNT_W),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[i]),
      .cnt_clr     (cnt_clr[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i]),
      .press_cnt   (press_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Registered OR of all press pulses, one cycle behind btn_press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |btn_press;
    end
  end

endmodule
